// File: rtl/imem_pkg.sv
// Shared types, constants and the halfword window merge for the imem responder.
`default_nettype none

package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RESP = 2'd3
  } imem_state_t;

  localparam int IMEM_WORD_BYTES = 8;
  localparam int IMEM_OFS_W      = 2;

  // Shift the {hi,lo} pair down by a whole number of halfwords and keep the low word.
  function automatic logic [63:0] imem_merge(input logic [63:0] hi,
                                             input logic [63:0] lo,
                                             input logic [IMEM_OFS_W-1:0] ofs);
    logic [127:0] cat;
    cat = {hi, lo} >> {ofs, 4'b0000};
    return cat[63:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/imem_line_buf.sv
// Two-entry {valid, word tag, data} store; each lookup port searches both entries.
`default_nettype none

module imem_line_buf #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] look_w0,
  input  logic [AW-1:0] look_w1,
  output logic          hit0,
  output logic          hit1,
  output logic [63:0]   data0,
  output logic [63:0]   data1,
  input  logic          upd_en,
  input  logic [AW-1:0] upd_w0,
  input  logic [63:0]   upd_d0,
  input  logic [AW-1:0] upd_w1,
  input  logic [63:0]   upd_d1,
  input  logic          upd_v1
);

  logic [1:0]    valid;
  logic [AW-1:0] tag  [2];
  logic [63:0]   data [2];

  // Each update replaces the whole buffer with the words of the finished transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= 2'b00;
      tag[0]  <= '0;
      tag[1]  <= '0;
      data[0] <= '0;
      data[1] <= '0;
    end else if (upd_en) begin
      valid   <= {upd_v1, 1'b1};
      tag[0]  <= upd_w0;
      tag[1]  <= upd_w1;
      data[0] <= upd_d0;
      data[1] <= upd_d1;
    end
  end

  always_comb begin
    hit0  = 1'b0;
    hit1  = 1'b0;
    data0 = '0;
    data1 = '0;
    for (int i = 0; i < 2; i++) begin
      if (valid[i] && tag[i] == look_w0) begin
        hit0  = 1'b1;
        data0 = data[i];
      end
      if (valid[i] && tag[i] == look_w1) begin
        hit1  = 1'b1;
        data1 = data[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/imem_responder.sv
// Instruction-memory responder: returns the 64-bit window at a halfword-aligned address.
// Optional two-word line buffer enabled by defining IMEM_LINE_BUF_EN.
`default_nettype none

module imem_responder
  import imem_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [63:0]   imem_addr,
  input  logic          imem_addr_valid,
  output logic [63:0]   imem_data,
  output logic          imem_data_valid,
  output logic          ram_en,
  output logic [AW-1:0] ram_addr,
  input  logic [63:0]   ram_rdata
);

  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  imem_state_t           state;
  logic [AW-1:0]         word;
  logic [IMEM_OFS_W-1:0] ofs;
  logic [63:0]           lo;
  logic [63:0]           hi;
  logic                  hi_known;

  logic [AW-1:0]         req_word;
  logic [AW-1:0]         req_next;
  logic [IMEM_OFS_W-1:0] req_ofs;
  logic                  need_hi;
  logic                  accept;
  logic                  hit0;
  logic                  hit1;
  logic [63:0]           bdata0;
  logic [63:0]           bdata1;
  logic                  all_hit;
  logic                  rd_w0;
  logic                  rd_w1_first;
  logic                  lo_rd;
  logic                  ram_en_c;
  logic [AW-1:0]         ram_addr_c;
  logic                  unused_addr;

  assign req_word    = imem_addr[AW+2:3];
  assign req_ofs     = imem_addr[2:1];
  assign req_next    = req_word + ONE;
  assign need_hi     = (req_ofs != '0);
  assign accept      = (state == IDLE) && imem_addr_valid;
  assign unused_addr = ^{imem_addr[63:AW+3], imem_addr[0]};

`ifdef IMEM_LINE_BUF_EN
  imem_line_buf #(.AW(AW)) u_line_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .look_w0 (req_word),
    .look_w1 (req_next),
    .hit0    (hit0),
    .hit1    (hit1),
    .data0   (bdata0),
    .data1   (bdata1),
    .upd_en  (state == RESP),
    .upd_w0  (word),
    .upd_d0  (lo),
    .upd_w1  (word + ONE),
    .upd_d1  (hi),
    .upd_v1  (ofs != '0)
  );
`else
  assign hit0   = 1'b0;
  assign hit1   = 1'b0;
  assign bdata0 = '0;
  assign bdata1 = '0;
`endif

  // Read W on a W miss; read W+1 up front when only W+1 misses; otherwise no read at accept.
  assign all_hit     = hit0 && (!need_hi || hit1);
  assign rd_w0       = accept && !hit0;
  assign rd_w1_first = accept && hit0 && need_hi && !hit1;
  assign lo_rd       = (state == LO) && (ofs != '0) && !hi_known;
  assign ram_en_c    = rd_w0 || rd_w1_first || lo_rd;

  always_comb begin
    ram_addr_c = word;
    if (rd_w1_first)
      ram_addr_c = req_next;
    else if (rd_w0)
      ram_addr_c = req_word;
    else if (lo_rd)
      ram_addr_c = word + ONE;
  end

  assign ram_en   = rst_n && ram_en_c;
  assign ram_addr = rst_n ? ram_addr_c : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      word            <= '0;
      ofs             <= '0;
      lo              <= '0;
      hi              <= '0;
      hi_known        <= 1'b0;
      imem_data       <= '0;
      imem_data_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            word     <= req_word;
            ofs      <= req_ofs;
            hi_known <= 1'b0;
            if (all_hit) begin
              lo              <= bdata0;
              hi              <= bdata1;
              imem_data       <= imem_merge(bdata1, bdata0, req_ofs);
              imem_data_valid <= 1'b1;
              state           <= RESP;
            end else if (rd_w1_first) begin
              lo    <= bdata0;
              state <= HI;
            end else begin
              hi       <= bdata1;
              hi_known <= need_hi && hit1;
              state    <= LO;
            end
          end
        end
        LO: begin
          lo <= ram_rdata;
          if (ofs == '0 || hi_known) begin
            imem_data       <= imem_merge(hi, ram_rdata, ofs);
            imem_data_valid <= 1'b1;
            state           <= RESP;
          end else begin
            state <= HI;
          end
        end
        HI: begin
          hi              <= ram_rdata;
          imem_data       <= imem_merge(ram_rdata, lo, ofs);
          imem_data_valid <= 1'b1;
          state           <= RESP;
        end
        RESP: begin
          imem_data_valid <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
